jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 88 ++++++++
 tb/tb_jk_reg_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with per-bit JK, up/down counter, parallel load and hold modes.
// Define JK_BANK_SAT_EN to make the counter saturate at its end points instead of wrapping.
module jk_reg_bank #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEn,
    input  logic [1:0]       iMode,
    input  logic [WIDTH-1:0] iJ,
    input  logic [WIDTH-1:0] iK,
    input  logic             iDir,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQ_bar,
    output logic             oTC,
    output logic             oOvf
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_CNT  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;

    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic [WIDTH-1:0] tgl;
    logic             at_end;

    // Ripple toggle chain: a bit toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        tgl    = '0;
        tgl[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            tgl[i] = tgl[i-1] & (iDir ? oQ[i-1] : ~oQ[i-1]);
        end
    end

    // The whole chain toggling means the step crosses the all-ones/all-zeros boundary.
    assign at_end = iDir ? (&oQ) : ~(|oQ);
    assign oTC    = (iMode == MODE_CNT) && iEn && at_end;

    always_comb begin
        q_nxt   = oQ;
        ovf_nxt = oOvf;
        case (iMode)
            MODE_JK: begin
                q_nxt = (iJ & ~oQ) | (~iK & oQ);
            end
            MODE_CNT: begin
`ifdef JK_BANK_SAT_EN
                if (at_end) begin
                    ovf_nxt = 1'b1;
                end else begin
                    q_nxt = oQ ^ tgl;
                end
`else
                q_nxt = oQ ^ tgl;
                if (at_end) begin
                    ovf_nxt = 1'b1;
                end
`endif
            end
            MODE_LOAD: begin
                q_nxt   = iD;
                ovf_nxt = 1'b0;
            end
            default: begin
                q_nxt   = oQ;
                ovf_nxt = oOvf;
            end
        endcase
    end

    // State changes only on the falling edge; oQ_bar is registered alongside oQ.
    always_ff @(negedge iClk) begin
        if (!iReset) begin
            oQ     <= RST_VAL;
            oQ_bar <= ~RST_VAL;
            oOvf   <= 1'b0;
        end else if (iEn) begin
            oQ     <= q_nxt;
            oQ_bar <= ~q_nxt;
            oOvf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: two instances (RST_VAL 00 and AA) share stimulus and
// are compared every rising edge against an arithmetic model, plus literal spot checks.
module tb_jk_reg_bank;

    localparam int unsigned      W    = 8;
    localparam logic [W-1:0]     RV_A = 8'hAA;
    localparam int unsigned      MAXV = (1 << W) - 1;

    logic         iClk;
    logic         iReset;
    logic         iEn;
    logic [1:0]   iMode;
    logic [W-1:0] iJ;
    logic [W-1:0] iK;
    logic         iDir;
    logic [W-1:0] iD;

    logic [W-1:0] q0, qb0, qa, qba;
    logic         tc0, ovf0, tca, ovfa;

    int checks = 0;
    int errors = 0;

    jk_reg_bank #(.WIDTH(W), .RST_VAL(8'h00)) dut0 (
        .iClk(iClk), .iReset(iReset), .iEn(iEn), .iMode(iMode), .iJ(iJ), .iK(iK),
        .iDir(iDir), .iD(iD), .oQ(q0), .oQ_bar(qb0), .oTC(tc0), .oOvf(ovf0)
    );

    jk_reg_bank #(.WIDTH(W), .RST_VAL(RV_A)) dut_a (
        .iClk(iClk), .iReset(iReset), .iEn(iEn), .iMode(iMode), .iJ(iJ), .iK(iK),
        .iDir(iDir), .iD(iD), .oQ(qa), .oQ_bar(qba), .oTC(tca), .oOvf(ovfa)
    );

    initial begin
        iClk = 1'b1;
        forever #5 iClk = ~iClk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the register value.
    logic [W-1:0] m0, ma;
    logic         mo0, moa;
    bit           mvalid = 1'b0;

    task automatic model_step(inout logic [W-1:0] q, inout logic ovf, input logic [W-1:0] rv);
        int unsigned v;
        if (!iReset) begin
            q   = rv;
            ovf = 1'b0;
        end else if (iEn) begin
            case (iMode)
                2'b00: begin
                    for (int b = 0; b < W; b++) begin
                        case ({iJ[b], iK[b]})
                            2'b01:   q[b] = 1'b0;
                            2'b10:   q[b] = 1'b1;
                            2'b11:   q[b] = ~q[b];
                            default: q[b] = q[b];
                        endcase
                    end
                end
                2'b01: begin
                    v = int'(q);
                    if (iDir) begin
                        if (v == MAXV) begin
`ifdef JK_BANK_SAT_EN
                            v = MAXV;
`else
                            v = 0;
`endif
                            ovf = 1'b1;
                        end else v = v + 1;
                    end else begin
                        if (v == 0) begin
`ifdef JK_BANK_SAT_EN
                            v = 0;
`else
                            v = MAXV;
`endif
                            ovf = 1'b1;
                        end else v = v - 1;
                    end
                    q = W'(v);
                end
                2'b10: begin
                    q   = iD;
                    ovf = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic exp_tc(input logic [W-1:0] q);
        if (iMode != 2'b01 || !iEn) return 1'b0;
        return iDir ? (int'(q) == MAXV) : (q == '0);
    endfunction

    always @(negedge iClk) begin
        model_step(m0, mo0, 8'h00);
        model_step(ma, moa, RV_A);
        if (!iReset) mvalid = 1'b1;
    end

    // Per-cycle comparison, away from the falling active edge.
    always @(posedge iClk) begin
        if (mvalid) begin
            chk("q0", q0, m0);
            chk("qb0", qb0, ~m0);
            chk("ovf0", W'(ovf0), W'(mo0));
            chk("tc0", W'(tc0), W'(exp_tc(m0)));
            chk("qa", qa, ma);
            chk("qba", qba, ~ma);
            chk("ovfa", W'(ovfa), W'(moa));
            chk("tca", W'(tca), W'(exp_tc(ma)));
        end
    end

    task automatic step(input logic rst, input logic en, input logic [1:0] mode,
                        input logic [W-1:0] j, input logic [W-1:0] k,
                        input logic [W-1:0] d, input logic dir);
        iReset = rst; iEn = en; iMode = mode; iJ = j; iK = k; iD = d; iDir = dir;
        @(negedge iClk);
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iReset = 1'b0; iEn = 1'b1; iMode = 2'b00; iJ = '1; iK = '1; iD = '0; iDir = 1'b0;

        // Reset held for three edges with all bits asked to toggle
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0);
            chk("rst_q", q0, 8'h00);
            chk("rst_qbar", qb0, 8'hFF);
            chk("rst_ovf", W'(ovf0), 8'h00);
            chk("rst_qa", qa, 8'hAA);
        end

        // Per-bit JK from 0F
        step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'h0F, 1'b0);
        chk("load_0f", q0, 8'h0F);
        step(1'b1, 1'b1, 2'b00, 8'hF0, 8'h3C, 8'h00, 1'b0);
        chk("jk_q", q0, 8'hF3);
        chk("jk_qbar", qb0, 8'h0C);
        chk("jk_model", m0, 8'hF3);

        // Count-up across the top boundary
        step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFE, 1'b1);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("up1_q", q0, 8'hFF);
        chk("up1_tc", W'(tc0), 8'h01);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
`ifdef JK_BANK_SAT_EN
        chk("up2_q", q0, 8'hFF);
        chk("up2_tc", W'(tc0), 8'h01);
`else
        chk("up2_q", q0, 8'h00);
        chk("up2_tc", W'(tc0), 8'h00);
`endif
        chk("up2_ovf", W'(ovf0), 8'h01);

        // Count-down with enable gaps
        step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'h02, 1'b0);
        chk("ld02_ovf", W'(ovf0), 8'h00);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("dn1_q", q0, 8'h01);
        step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("dn2_q", q0, 8'h01);
        chk("dn2_tc", W'(tc0), 8'h00);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("dn3_q", q0, 8'h00);
        chk("dn3_tc", W'(tc0), 8'h01);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef JK_BANK_SAT_EN
        chk("dn4_q", q0, 8'h00);
`else
        chk("dn4_q", q0, 8'hFF);
`endif
        chk("dn4_ovf", W'(ovf0), 8'h01);

        // Mode 11 holds value and sticky flag despite busy inputs
        step(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 8'h55, 1'b1);
`ifdef JK_BANK_SAT_EN
        chk("hold_q", q0, 8'h00);
`else
        chk("hold_q", q0, 8'hFF);
`endif
        chk("hold_ovf", W'(ovf0), 8'h01);

        // Reset in the middle of a count
        step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'h05, 1'b1);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("mid_q", qa, 8'h08);
        step(1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("mid_rst_qa", qa, 8'hAA);
        chk("mid_rst_ovf", W'(ovfa), 8'h00);
        chk("mid_rst_q0", q0, 8'h00);
        step(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("resume_qa", qa, 8'hAB);
        chk("resume_q0", q0, 8'h01);
        chk("resume_model", ma, 8'hAB);

        // More JK patterns, then a gated load that must be ignored
        step(1'b1, 1'b1, 2'b00, 8'hAA, 8'h55, 8'h00, 1'b0);
        chk("jk_set_clr", q0, 8'hAA);
        chk("jk_set_clr_a", qa, 8'hAA);
        step(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0);
        chk("jk_toggle", q0, 8'h55);
        step(1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h33, 1'b0);
        chk("gated_load", q0, 8'h55);
        step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'h33, 1'b0);
        chk("load_33", qa, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
